// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-select adder.
//   SLICE_W : width of the shared carry-select slice
//   state_e : controller state encoding
//   nslice  : number of slice passes needed for a given operand width
package csa_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/csa_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for csa_seq_adder_ctrl.
//   master : operand producer + result consumer side
//   slave  : adder controller side
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : controller is in RUN or DONE
interface csa_seq_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/csa_slice4.sv
// Combinational 4-bit carry-select slice.
//   a4, b4 : 4-bit operands
//   c      : carry in, selects between the two precomputed chains
//   s4     : 4-bit sum
//   co     : carry out
module csa_slice4
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               c,
  output logic [SLICE_W-1:0] s4,
  output logic               co
);

  logic [SLICE_W-1:0] w_s0;
  logic [SLICE_W-1:0] w_s1;
  logic [SLICE_W:0]   w_c0;
  logic [SLICE_W:0]   w_c1;

  // Two ripple chains evaluated in parallel: one assumes carry-in 0, the other 1.
  always_comb begin
    w_s0    = '0;
    w_s1    = '0;
    w_c0    = '0;
    w_c1    = '0;
    w_c1[0] = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      w_s0[i]   = a4[i] ^ b4[i] ^ w_c0[i];
      w_c0[i+1] = (a4[i] & b4[i]) | (w_c0[i] & (a4[i] ^ b4[i]));
      w_s1[i]   = a4[i] ^ b4[i] ^ w_c1[i];
      w_c1[i+1] = (a4[i] & b4[i]) | (w_c1[i] & (a4[i] ^ b4[i]));
    end
  end

  assign s4 = c ? w_s1 : w_s0;
  assign co = c ? w_c1[SLICE_W] : w_c0[SLICE_W];

endmodule

// File: rtl/csa_seq_adder_ctrl.sv
// Multi-cycle wide adder: sequences one shared 4-bit carry-select slice over
// the operands, one nibble per clock from LSB to MSB, with the inter-slice
// carry held in a register.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of csa_seq_adder_ctrl_if (operand/result handshakes, busy)
module csa_seq_adder_ctrl
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  csa_seq_adder_ctrl_if.slave   bus
);

  localparam int unsigned NSLICE = nslice(WIDTH);
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
    $error("csa_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_out_valid;

  logic [SLICE_W-1:0] w_s4;
  logic               w_co;
  logic               w_accept;
  logic               w_last;
  logic [IDX_W+1:0]   w_lsb;

  csa_slice4 u_slice (
    .a4 (r_a[SLICE_W-1:0]),
    .b4 (r_b[SLICE_W-1:0]),
    .c  (r_carry),
    .s4 (w_s4),
    .co (w_co)
  );

  assign w_accept = (r_state == IDLE) && bus.in_valid && !rst;
  assign w_last   = (r_idx == IDX_W'(NSLICE - 1));
  // Bit offset of the current nibble: idx * 4.
  assign w_lsb    = {r_idx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_lsb +: SLICE_W] <= w_s4;
          r_carry <= w_co;
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_cout      <= w_co;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // No bypass: IDLE is always visited before the next accept.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// Directed self-checking bench for csa_seq_adder_ctrl (WIDTH=16).
module tb_csa_seq_adder_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;

  csa_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  csa_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands and wait for the accept edge; returns just after it.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input string tag, input logic drop_valid);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check({tag, "_accept_timeout"}, 0, 1);
    step();
    if (drop_valid) bus.in_valid = 1'b0;
    // Operands may change freely after the accept edge.
    bus.a   = ~a;
    bus.b   = a ^ b;
    bus.cin = ~cin;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_in_ready_run"}, bus.in_ready, 0);
  endtask

  // Called just after the accept edge; checks latency and result.
  task automatic wait_result(input logic [15:0] exp_sum, input logic exp_cout, input string tag);
    int cnt;
    cnt = 1;
    while (!bus.out_valid && cnt <= 20) begin
      step();
      if (!bus.out_valid) cnt++;
    end
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_latency"}, cnt, LAT);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cout"}, bus.cout, exp_cout);
    if (bus.out_ready) begin
      step();
      check({tag, "_out_valid_drop"}, bus.out_valid, 0);
      check({tag, "_idle"}, bus.busy, 0);
    end
  endtask

  logic [15:0] ra [3];
  logic [15:0] rb [3];
  logic        rc [3];
  int          acc [3];
  logic [16:0] ref_res;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    start(16'h1234, 16'h4321, 1'b0, "t1", 1'b1);
    wait_result(16'h5555, 1'b0, "t1");

    start(16'hFFFF, 16'h0000, 1'b1, "t2", 1'b1);
    wait_result(16'h0000, 1'b1, "t2");

    start(16'hFFFF, 16'hFFFF, 1'b1, "t3a", 1'b1);
    wait_result(16'hFFFF, 1'b1, "t3a");
    start(16'h8000, 16'h8000, 1'b0, "t3b", 1'b1);
    wait_result(16'h0000, 1'b1, "t3b");

    // Backpressure in DONE with new operands pending.
    bus.out_ready = 1'b0;
    start(16'h00F0, 16'h0F0F, 1'b0, "bp", 1'b1);
    wait_result(16'h0FFF, 1'b0, "bp");
    bus.a        = 16'h0001;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_sum", bus.sum, 16'h0FFF);
      check("bp_hold_cout", bus.cout, 0);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_in_ready", bus.in_ready, 1);
    start(16'h0001, 16'h0001, 1'b0, "bp2", 1'b1);
    wait_result(16'h0002, 1'b0, "bp2");

    // Reset in the middle of RUN.
    start(16'h00FF, 16'h0001, 1'b0, "rr", 1'b1);
    step();
    rst = 1'b1;
    #1;
    check("rr_out_valid", bus.out_valid, 0);
    check("rr_sum", bus.sum, 0);
    check("rr_busy", bus.busy, 0);
    check("rr_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    start(16'h00FF, 16'h0001, 1'b0, "rr2", 1'b1);
    wait_result(16'h0100, 1'b0, "rr2");

    // Streaming with in_valid and out_ready held high.
    for (int k = 0; k < 3; k++) begin
      ra[k] = 16'($urandom);
      rb[k] = 16'($urandom);
      rc[k] = 1'($urandom);
    end
    bus.out_ready = 1'b1;
    bus.a         = ra[0];
    bus.b         = rb[0];
    bus.cin       = rc[0];
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) check("st_accept_timeout", 0, 1);
      step();
      acc[k] = cyc;
      if (k < 2) begin
        bus.a   = ra[k+1];
        bus.b   = rb[k+1];
        bus.cin = rc[k+1];
      end else begin
        bus.in_valid = 1'b0;
      end
      ref_res = {1'b0, ra[k]} + {1'b0, rb[k]} + {16'h0, rc[k]};
      wait_result(ref_res[15:0], ref_res[16], "st");
    end
    check("st_gap01", acc[1] - acc[0], 6);
    check("st_gap12", acc[2] - acc[1], 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
